// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side counterpart of the VGA X/Y timing generator. Rebuilds pixel
//   coordinates and a data-enable from hsync_n/vsync_n alone, measures line
//   and frame lengths and locks after LOCK_FRAMES consecutive good frames.
//
// Ports
//   clk25     in   pixel clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   hsync_n   in   horizontal sync, active low
//   vsync_n   in   vertical sync, active low
//   pixel_x   out  active X (0 when de=0)
//   pixel_y   out  active Y (0 when de=0)
//   de        out  locked and inside the active window
//   locked    out  timing locked
//   new_frame out  one-cycle pulse per vsync falling edge while locked
//   sync_err  out  one-cycle pulse on loss of lock
//
// Configuration
//   SYNC_INPUT_EN  when defined, two extra flops on each sync input for
//                  asynchronous sources (+2 cycles on every latency).
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_START     = 144,
    parameter int unsigned V_START     = 35,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       hsync_n,
    input  logic       vsync_n,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       de,
    output logic       locked,
    output logic       new_frame,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    localparam logic [10:0] H_TOTAL_C   = 11'(H_TOTAL);
    localparam logic [11:0] LINE_LEN_C  = 12'(H_TOTAL);
    localparam logic [10:0] FRAME_LEN_C = 11'(V_TOTAL);
    localparam logic [10:0] H_LO        = 11'(H_START);
    localparam logic [10:0] H_HI        = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  H_LO10      = 10'(H_START);
    localparam logic [9:0]  V_LO        = 10'(V_START);
    localparam logic [9:0]  V_HI        = 10'(V_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_C      = 4'(LOCK_FRAMES);
    localparam logic [10:0] H_MAX       = '1;
    localparam logic [9:0]  V_MAX       = '1;

    logic        hs_src;
    logic        vs_src;
    logic        hs_d1;
    logic        hs_d2;
    logic        vs_d1;
    logic        vs_d2;
    logic        hs_fall;
    logic        vs_fall;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [11:0] line_len;
    logic [10:0] frame_len;
    logic        line_ok;
    logic        line_bad;
    logic        frame_good;
    state_t      state;
    logic [3:0]  good_cnt;
    logic [3:0]  good_inc;
    logic        lose_lock;
    logic        gain_lock;
    logic        lock_next;
    logic        h_in_win;
    logic        v_in_win;
    logic [9:0]  px_calc;
    logic [9:0]  py_calc;

    // ------------------------------------------------------------------
    // Optional synchroniser in front of the edge-detect stage
    // ------------------------------------------------------------------
`ifdef SYNC_INPUT_EN
    logic [1:0] hs_meta;
    logic [1:0] vs_meta;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hs_meta <= '1;
            vs_meta <= '1;
        end else begin
            hs_meta <= {hs_meta[0], hsync_n};
            vs_meta <= {vs_meta[0], vsync_n};
        end
    end

    assign hs_src = hs_meta[1];
    assign vs_src = vs_meta[1];
`else
    assign hs_src = hsync_n;
    assign vs_src = vsync_n;
`endif

    // Edge-detect stage; idles high so reset release never fakes an edge
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hs_d1 <= 1'b1;
            hs_d2 <= 1'b1;
            vs_d1 <= 1'b1;
            vs_d2 <= 1'b1;
        end else begin
            hs_d1 <= hs_src;
            hs_d2 <= hs_d1;
            vs_d1 <= vs_src;
            vs_d2 <= vs_d1;
        end
    end

    // ------------------------------------------------------------------
    // Combinational measurement and lock decisions
    // ------------------------------------------------------------------
    always_comb begin
        hs_fall   = !hs_d1 && hs_d2;
        vs_fall   = !vs_d1 && vs_d2;
        line_len  = {1'b0, h_cnt} + 12'd1;
        frame_len = {1'b0, v_cnt} + 11'd1;
        // A line ending together with vsync still belongs to the frame being closed
        line_ok    = !hs_fall || (line_len == LINE_LEN_C);
        frame_good = !line_bad && line_ok && (frame_len == FRAME_LEN_C);
        good_inc   = good_cnt + 4'd1;

        lose_lock = (state == ST_LOCKED) &&
                    (!line_ok ||
                     (vs_fall && (frame_len != FRAME_LEN_C)) ||
                     (h_cnt == H_TOTAL_C));
        gain_lock = (state == ST_MEASURE) && vs_fall && frame_good &&
                    (good_inc == LOCK_C);
        // de follows the lock value being registered this edge, so it drops
        // together with locked instead of one cycle later
        lock_next = gain_lock || ((state == ST_LOCKED) && !lose_lock);

        h_in_win = (h_cnt >= H_LO) && (h_cnt < H_HI);
        v_in_win = (v_cnt >= V_LO) && (v_cnt < V_HI);
        // Inside the window the offset is below H_ACTIVE, so 10 bits suffice
        px_calc  = h_cnt[9:0] - H_LO10;
        py_calc  = v_cnt - V_LO;
    end

    // ------------------------------------------------------------------
    // Position counters and line-quality flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            line_bad <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_cnt <= '0;
            end else if (h_cnt != H_MAX) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (vs_fall) begin
                v_cnt <= '0;
            end else if (hs_fall && (v_cnt != V_MAX)) begin
                v_cnt <= v_cnt + 10'd1;
            end

            if (vs_fall) begin
                line_bad <= 1'b0;
            end else if (hs_fall && (line_len != LINE_LEN_C)) begin
                line_bad <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEARCH;
            good_cnt  <= '0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            sync_err  <= 1'b0;
            new_frame <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    if (vs_fall) begin
                        state    <= ST_MEASURE;
                        good_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (vs_fall) begin
                        if (!frame_good) begin
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_inc;
                            if (gain_lock) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (lose_lock) begin
                        state    <= ST_SEARCH;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end else if (vs_fall) begin
                        new_frame <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_SEARCH;
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered video outputs, one cycle behind the counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            de      <= 1'b0;
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (lock_next && h_in_win && v_in_win) begin
            de      <= 1'b1;
            pixel_x <= px_calc;
            pixel_y <= py_calc;
        end else begin
            de      <= 1'b0;
            pixel_x <= '0;
            pixel_y <= '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    // Reduced timing keeps whole frames short
    localparam int HT    = 40;
    localparam int VT    = 20;
    localparam int HS    = 8;
    localparam int VS    = 3;
    localparam int HA    = 24;
    localparam int VA    = 14;
    localparam int LF    = 2;
    localparam int HSW   = 4;
    localparam int NOBAD = 99999;
`ifdef SYNC_INPUT_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic       clk25   = 1'b0;
    logic       rst_n   = 1'b0;
    logic       hsync_n = 1'b1;
    logic       vsync_n = 1'b1;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       de;
    logic       locked;
    logic       new_frame;
    logic       sync_err;

    typedef struct packed {
        logic       de;
        logic       locked;
        logic       new_frame;
        logic       sync_err;
        logic [9:0] px;
        logic [9:0] py;
    } out_t;

    out_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    vga_sync_decoder #(
        .H_TOTAL    (HT),
        .V_TOTAL    (VT),
        .H_START    (HS),
        .V_START    (VS),
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk25    (clk25),
        .rst_n    (rst_n),
        .hsync_n  (hsync_n),
        .vsync_n  (vsync_n),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .de       (de),
        .locked   (locked),
        .new_frame(new_frame),
        .sync_err (sync_err)
    );

    initial forever #5 clk25 = ~clk25;

    // ------------------------------------------------------------------
    // Reference model: works on absolute edge indices and per-frame lists
    // of measured line lengths; pushes the expected outputs after each edge.
    // ------------------------------------------------------------------
    typedef enum {M_SEARCH, M_MEASURE, M_LOCKED} mode_t;

    int    edge_no = 0;
    int    hzero   = 0;
    int    vl      = 0;
    int    good    = 0;
    mode_t mode    = M_SEARCH;
    bit    pend_h  = 1'b0;
    bit    pend_v  = 1'b0;
    logic [3:0] hh = '1;
    logic [3:0] vh = '1;
    int    lines[$];

    always @(posedge clk25) begin : model
        out_t e;
        int   hb;
        int   vb;
        int   ll;
        int   fl;
        bit   lose;
        bit   nf;
        bit   ok;
        edge_no = edge_no + 1;
        e = '0;
        if (!rst_n) begin
            hh     = '1;
            vh     = '1;
            pend_h = 1'b0;
            pend_v = 1'b0;
            hzero  = edge_no;
            vl     = 0;
            good   = 0;
            mode   = M_SEARCH;
            lines.delete();
        end else begin
            hb = edge_no - 1 - hzero;
            if (hb > 2047) hb = 2047;
            vb   = vl;
            ll   = hb + 1;
            fl   = vb + 1;
            lose = 1'b0;
            nf   = 1'b0;
            case (mode)
                M_LOCKED: begin
                    lose = (pend_h && ll != HT) || (pend_v && fl != VT) || (hb == HT);
                    if (lose) begin
                        mode = M_SEARCH;
                        good = 0;
                    end else if (pend_v) begin
                        nf = 1'b1;
                    end
                end
                M_SEARCH: begin
                    if (pend_v) begin
                        mode = M_MEASURE;
                        good = 0;
                    end
                end
                default: begin
                    if (pend_v) begin
                        ok = (fl == VT) && (!pend_h || ll == HT);
                        foreach (lines[i]) if (lines[i] != HT) ok = 1'b0;
                        good = ok ? good + 1 : 0;
                        if (good == LF) mode = M_LOCKED;
                    end
                end
            endcase
            if (pend_h) hzero = edge_no;
            if (pend_v) begin
                lines.delete();
                vl = 0;
            end else if (pend_h) begin
                lines.push_back(ll);
                if (vl < 1023) vl = vl + 1;
            end
            e.locked    = (mode == M_LOCKED);
            e.sync_err  = lose;
            e.new_frame = nf;
            if (e.locked && hb >= HS && hb < HS + HA && vb >= VS && vb < VS + VA) begin
                e.de = 1'b1;
                e.px = 10'(hb - HS);
                e.py = 10'(vb - VS);
            end
            hh = {hh[2:0], hsync_n};
            vh = {vh[2:0], vsync_n};
            pend_h = !hh[SD] && hh[SD+1];
            pend_v = !vh[SD] && vh[SD+1];
        end
        sbq.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor: one expected entry per edge, compared mid-cycle
    // ------------------------------------------------------------------
    always @(negedge clk25) begin : monitor
        out_t want;
        out_t got;
        got.de        = de;
        got.locked    = locked;
        got.new_frame = new_frame;
        got.sync_err  = sync_err;
        got.px        = pixel_x;
        got.py        = pixel_y;
        checks = checks + 1;
        if (sbq.size() == 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_empty t=%0t: got no expected entry, required one", $time);
        end else begin
            want = sbq.pop_front();
            if (!rst_n) want = '0;   // reset clears outputs immediately
            if (got !== want) begin
                errors = errors + 1;
                $display("FAIL outputs t=%0t: got de=%b locked=%b new_frame=%b sync_err=%b x=%0d y=%0d, required de=%b locked=%b new_frame=%b sync_err=%b x=%0d y=%0d",
                         $time, got.de, got.locked, got.new_frame, got.sync_err, got.px, got.py,
                         want.de, want.locked, want.new_frame, want.sync_err, want.px, want.py);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic h, input logic v);
        @(posedge clk25);
        #1;
        hsync_n = h;
        vsync_n = v;
    endtask

    task automatic line(input int len, input int hsw, input bit vlow);
        for (int c = 0; c < len; c++) cyc(c >= hsw, !vlow);
    endtask

    task automatic frame(input int nlines, input int bad_line, input int bad_len, input int vsw);
        for (int l = 0; l < nlines; l++)
            line((l == bad_line) ? bad_len : HT, HSW, l < vsw);
    endtask

    task automatic set_reset(input logic r);
        @(posedge clk25);
        #1;
        rst_n = r;
    endtask

    initial begin : stim
        int nl;
        int len;
        // Reset held with random sync activity
        rst_n = 1'b0;
        for (int i = 0; i < 150; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cyc(1'b1, 1'b1);
        set_reset(1'b1);
        for (int i = 0; i < int'($urandom_range(5, 30)); i++) cyc(1'b1, 1'b1);

        // Standard timing, lock on the third vsync edge
        repeat (4) frame(VT, NOBAD, 0, 1);

        // One long line while locked, then relock
        frame(VT, 5, HT + 1, 1);
        repeat (3) frame(VT, NOBAD, 0, 1);

        // Missing hsync while locked; saturated line length stays bad in MEASURE
        frame(VT, 7, 2048 + HT, 1);
        frame(VT, 3, 2048 + HT, 1);
        repeat (3) frame(VT, NOBAD, 0, 1);

        // Reset pulse mid-line in the active area, then full relock sequence
        frame(6, NOBAD, 0, 1);
        for (int c = 0; c < HS + 12; c++) cyc(c >= HSW, 1'b1);
        set_reset(1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        set_reset(1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1);
        repeat (4) frame(VT, NOBAD, 0, 1);

        // Randomised line/frame lengths and sync widths
        for (int f = 0; f < 14; f++) begin
            nl = VT;
            if ($urandom_range(0, 4) == 0) nl = ($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1;
            for (int l = 0; l < nl; l++) begin
                len = HT;
                case ($urandom_range(0, 39))
                    0: len = HT + 1;
                    1: len = HT - 1;
                    default: len = HT;
                endcase
                line(len, int'($urandom_range(1, 5)), l < 2 && (l == 0 || $urandom_range(0, 1) == 1));
            end
        end
        repeat (3) frame(VT, NOBAD, 0, 1);

        // Sync stops entirely
        for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1);
        @(posedge clk25);
        @(negedge clk25);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
